// File: rtl/vz_load_arbiter.sv
// Buffers VZ loader writes and drains them into RAM by borrowing the Z80 bus through BUSRQ/BUSAK.
// Latency: an entry popped in cycle N is written in N+1. Backpressure: ld_full; a write while full is dropped and sets ovf_err.

// Small synchronous FIFO with registered pointers and a combinational head.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: a push while full and a pop while empty are both ignored.
module vz_load_fifo #(
  parameter int AW = 3,
  parameter int DW = 24
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rptr];

  always_ff @(posedge I_CLK) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // Pointers wrap naturally at 2**AW.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module vz_load_arbiter #(
  parameter int FIFO_AW  = 3,
  parameter int HOLD_CYC = 16,
  parameter int TIMEOUT  = 4096
) (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic        dl_active,
  input  logic        ld_wr,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_full,
  output logic        cpu_busrq_n,
  input  logic        cpu_busak_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_wr,
  output logic        load_done,
  output logic        grant_err,
  output logic        ovf_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_REL} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [23:0]   w_head;
  logic          w_busak_lost;
  logic          w_done;
  logic [15:0]   r_drn_addr;
  logic [7:0]    r_drn_data;
  logic          r_drn_wr;
  logic [TW-1:0] r_to_ctr;
  logic [HW-1:0] r_idle_ctr;
  logic          r_grant_err;
  logic          r_ovf_err;
  logic          r_dl_q;
  logic          r_done_pend;

  assign w_push       = ld_wr && !w_full;
  assign w_pop        = (r_state == S_GRANT) && !w_empty && !cpu_busak_n;
  assign w_busak_lost = (r_state == S_GRANT) && cpu_busak_n;
  assign w_done       = r_done_pend && w_empty && ((r_state == S_IDLE) || (r_state == S_REL));

  vz_load_fifo #(.AW(FIFO_AW), .DW(24)) u_fifo (
    .I_CLK   (I_CLK),
    .I_RST   (I_RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({ld_addr, ld_data}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge I_CLK) begin
    if (I_RST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_REQ;
      S_REQ:   if (!cpu_busak_n) w_next = S_GRANT;
      S_GRANT: begin
        if (cpu_busak_n) w_next = S_IDLE;
        else if (w_empty && (!dl_active || (r_idle_ctr == HOLD_MAX))) w_next = S_REL;
      end
      S_REL:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Drain registers own the RAM port only while the bus is granted; RELEASE blanks the strobe.
  always_comb begin
    cpu_busrq_n = !((r_state == S_REQ) || (r_state == S_GRANT));
    ram_addr    = cpu_addr;
    ram_data    = cpu_dout;
    ram_wr      = cpu_wr;
    case (r_state)
      S_GRANT: begin
        ram_addr = r_drn_addr;
        ram_data = r_drn_data;
        ram_wr   = r_drn_wr && !w_busak_lost;
      end
      S_REL:   ram_wr = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_drn_addr <= '0;
      r_drn_data <= '0;
      r_drn_wr   <= 1'b0;
    end else begin
      r_drn_wr <= w_pop;
      if (w_pop) begin
        r_drn_addr <= w_head[23:8];
        r_drn_data <= w_head[7:0];
      end
    end
  end

  // Both counters saturate at their compare value so they never wrap back under it.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_to_ctr   <= '0;
      r_idle_ctr <= '0;
    end else begin
      if (r_state != S_REQ)       r_to_ctr <= '0;
      else if (r_to_ctr != TO_MAX) r_to_ctr <= r_to_ctr + 1'b1;
      if ((r_state != S_GRANT) || !w_empty) r_idle_ctr <= '0;
      else if (r_idle_ctr != HOLD_MAX)      r_idle_ctr <= r_idle_ctr + 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_grant_err <= 1'b0;
      r_ovf_err   <= 1'b0;
      r_dl_q      <= 1'b0;
      r_done_pend <= 1'b0;
    end else begin
      if (((r_state == S_REQ) && cpu_busak_n && (r_to_ctr == TO_MAX)) || w_busak_lost)
        r_grant_err <= 1'b1;
      if (ld_wr && w_full) r_ovf_err <= 1'b1;
      r_dl_q <= dl_active;
      // A new download cancels a pending completion; a fresh fall re-arms it.
      if (dl_active && !r_dl_q)      r_done_pend <= 1'b0;
      else if (!dl_active && r_dl_q) r_done_pend <= 1'b1;
      else if (w_done)               r_done_pend <= 1'b0;
    end
  end

  assign ld_full   = w_full;
  assign load_done = w_done;
  assign grant_err = r_grant_err;
  assign ovf_err   = r_ovf_err;
endmodule

// File: tb/tb_vz_load_arbiter.sv
// Scoreboard bench for vz_load_arbiter: expected RAM writes are queued at issue time and
// popped by an independent monitor; a behavioural Z80 answers BUSRQ after a programmable delay.
module tb_vz_load_arbiter;
  localparam int HOLD_CYC = 16;
  localparam int TIMEOUT  = 4096;
  localparam int DEPTH    = 8;

  typedef struct packed { logic [15:0] a; logic [7:0] d; } ent_t;

  logic        I_CLK = 1'b0;
  logic        I_RST;
  logic        dl_active, ld_wr, ld_full;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        cpu_busrq_n, cpu_busak_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wr, load_done, grant_err, ovf_err;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  ent_t sb[$];
  bit   mon_en = 1'b0;
  int   wr_seen = 0;
  int   first_wr_cyc = 0;
  int   last_wr_cyc = 0;
  int   done_cnt = 0;
  bit   ak_never = 1'b0;
  int   ak_dly = 1;
  int   ak_cnt = 0;

  vz_load_arbiter dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .dl_active(dl_active), .ld_wr(ld_wr),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_full(ld_full),
    .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wr(ram_wr), .load_done(load_done), .grant_err(grant_err), .ovf_err(ovf_err)
  );

  always #5 I_CLK = ~I_CLK;
  always @(posedge I_CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Z80: acknowledges ak_dly cycles after seeing BUSRQ low, releases as soon as BUSRQ rises.
  initial begin
    cpu_busak_n = 1'b1;
    forever begin
      @(negedge I_CLK);
      if (!cpu_busrq_n && !ak_never) begin
        if (ak_cnt >= ak_dly) cpu_busak_n = 1'b0;
        else ak_cnt++;
      end else begin
        ak_cnt = 0;
        cpu_busak_n = 1'b1;
      end
    end
  end

  // Monitor: every loader write reaching RAM must match the oldest expected entry.
  initial begin
    ent_t e;
    forever begin
      @(posedge I_CLK);
      #1;
      if (load_done) done_cnt++;
      if (mon_en && ram_wr) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ram_wr_unexpected: addr 0x%0h data 0x%0h with no pending entry", ram_addr, ram_data);
        end else begin
          e = sb.pop_front();
          chk("ram_addr", {16'h0, ram_addr}, {16'h0, e.a});
          chk("ram_data", {24'h0, ram_data}, {24'h0, e.d});
        end
        if (wr_seen == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_seen++;
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input bit accept);
    @(negedge I_CLK);
    ld_wr = 1'b1;
    ld_addr = a;
    ld_data = d;
    if (accept) sb.push_back({a, d});
  endtask

  task automatic wait_drain(input int maxc, input string nm);
    int n = 0;
    do begin
      @(posedge I_CLK);
      #2;
      n++;
    end while (sb.size() != 0 && n < maxc);
    chk(nm, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_busrq(input logic v, input int maxc, input string nm);
    int n = 0;
    do begin
      @(posedge I_CLK);
      #1;
      n++;
    end while (cpu_busrq_n !== v && n < maxc);
    chk(nm, cpu_busrq_n, v);
  endtask

  task automatic do_reset(input int n);
    @(negedge I_CLK);
    I_RST = 1'b1;
    repeat (n) @(negedge I_CLK);
    I_RST = 1'b0;
  endtask

  initial begin
    int c0;
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int c0, w;
    I_RST = 1'b1; dl_active = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
    cpu_addr = 16'h1234; cpu_dout = 8'h56; cpu_wr = 1'b1;

    // Reset state and pass-through
    repeat (2) @(posedge I_CLK);
    #1;
    chk("rst_busrq_n", cpu_busrq_n, 1'b1);
    chk("rst_ram_wr", ram_wr, 1'b1);
    chk("rst_ram_addr", {16'h0, ram_addr}, 32'h1234);
    chk("rst_ram_data", {24'h0, ram_data}, 32'h56);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_grant_err", grant_err, 1'b0);
    chk("rst_ovf_err", ovf_err, 1'b0);
    chk("rst_ld_full", ld_full, 1'b0);
    @(negedge I_CLK);
    cpu_wr = 1'b0;
    @(posedge I_CLK);
    #1;
    chk("rst_ram_wr_follow", ram_wr, 1'b0);
    @(negedge I_CLK);
    I_RST = 1'b0;
    mon_en = 1'b1;

    // Burst of five, ack three cycles late, then hold timing
    @(negedge I_CLK);
    dl_active = 1'b1;
    ak_dly = 3;
    wr_seen = 0;
    for (int i = 0; i < 5; i++) wr(16'h7AE9 + 16'(i), 8'hA0 + 8'(i), 1'b1);
    @(negedge I_CLK);
    ld_wr = 1'b0;
    wait_drain(60, "burst_drain");
    chk("burst_count", wr_seen, 5);
    chk("burst_consecutive", last_wr_cyc - first_wr_cyc, 4);
    w = last_wr_cyc;
    while (cyc < w + HOLD_CYC) begin
      @(posedge I_CLK);
      #1;
    end
    chk("hold_busrq_still_low", cpu_busrq_n, 1'b0);
    @(posedge I_CLK);
    #1;
    chk("hold_busrq_released", cpu_busrq_n, 1'b1);

    // Random traffic, never more than seven outstanding so the FIFO cannot fill
    for (int i = 0; i < 300; i++) begin
      @(negedge I_CLK);
      if (($urandom_range(0, 2) != 0) && (sb.size() < 7)) begin
        ld_wr = 1'b1;
        ld_addr = 16'($urandom);
        ld_data = 8'($urandom);
        sb.push_back({ld_addr, ld_data});
      end else begin
        ld_wr = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) ak_dly = $urandom_range(0, 4);
    end
    @(negedge I_CLK);
    ld_wr = 1'b0;
    wait_drain(200, "rand_drain");
    wait_busrq(1'b1, 60, "rand_release");

    // Overflow with the bus withheld
    ak_never = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr(16'h8000 + 16'(i), 8'(i * 7 + 3), sb.size() < DEPTH);
      @(posedge I_CLK);
      #1;
      if (i == 6) chk("ovf_not_full_at_7", ld_full, 1'b0);
      if (i == 7) begin
        chk("ovf_full_at_8", ld_full, 1'b1);
        chk("ovf_err_before_drop", ovf_err, 1'b0);
      end
      if (i == 8) chk("ovf_err_set", ovf_err, 1'b1);
    end
    @(negedge I_CLK);
    ld_wr = 1'b0;
    ak_never = 1'b0;
    ak_dly = 1;
    wait_drain(100, "ovf_drain");
    chk("ovf_not_full_after", ld_full, 1'b0);
    chk("ovf_err_sticky", ovf_err, 1'b1);
    wait_busrq(1'b1, 60, "ovf_release");

    // Download ends with two entries pending
    dl_active = 1'b0;
    do_reset(2);
    chk("rst_clears_ovf", ovf_err, 1'b0);
    @(negedge I_CLK);
    dl_active = 1'b1;
    ak_dly = 2;
    wr(16'h9000, 8'h11, 1'b1);
    wr(16'h9001, 8'h22, 1'b1);
    @(negedge I_CLK);
    ld_wr = 1'b0;
    dl_active = 1'b0;
    done_cnt = 0;
    wait_drain(40, "end_drain");
    chk("end_no_done_before_write", done_cnt, 0);
    wait_busrq(1'b1, 5, "end_release");
    repeat (10) @(posedge I_CLK);
    #1;
    chk("end_done_once", done_cnt, 1);

    // Download ends with nothing pending: pulse on the following cycle
    @(negedge I_CLK);
    dl_active = 1'b1;
    repeat (3) @(negedge I_CLK);
    dl_active = 1'b0;
    @(posedge I_CLK);
    #1;
    chk("idle_done_pulse", load_done, 1'b1);
    @(posedge I_CLK);
    #1;
    chk("idle_done_single", load_done, 1'b0);

    // Reset in the middle of a drain
    @(negedge I_CLK);
    dl_active = 1'b1;
    ak_never = 1'b1;
    for (int i = 0; i < 6; i++) wr(16'hB000 + 16'(i), 8'hC0 + 8'(i), 1'b1);
    @(negedge I_CLK);
    ld_wr = 1'b0;
    wr_seen = 0;
    ak_dly = 0;
    ak_never = 1'b0;
    c0 = 0;
    while (wr_seen < 2 && c0 < 40) begin
      @(posedge I_CLK);
      #2;
      c0++;
    end
    chk("mid_two_written", wr_seen, 2);
    @(negedge I_CLK);
    I_RST = 1'b1;
    @(posedge I_CLK);
    #1;
    chk("mid_rst_ram_wr", ram_wr, 1'b0);
    chk("mid_rst_busrq_n", cpu_busrq_n, 1'b1);
    sb.delete();
    @(negedge I_CLK);
    I_RST = 1'b0;
    repeat (20) @(posedge I_CLK);
    #1;
    chk("mid_fifo_flushed", cpu_busrq_n, 1'b1);
    chk("mid_no_more_writes", wr_seen, 2);

    // Bus never acknowledged
    ak_never = 1'b1;
    wr(16'hA000, 8'h5A, 1'b1);
    @(negedge I_CLK);
    ld_wr = 1'b0;
    wait_busrq(1'b0, 10, "to_req_entry");
    c0 = cyc;
    while (cyc < c0 + TIMEOUT - 1) begin
      @(posedge I_CLK);
      #1;
    end
    chk("to_err_not_early", grant_err, 1'b0);
    repeat (2) @(posedge I_CLK);
    #1;
    chk("to_err_set", grant_err, 1'b1);
    chk("to_busrq_held", cpu_busrq_n, 1'b0);
    repeat (5) @(posedge I_CLK);
    #1;
    chk("to_busrq_still_held", cpu_busrq_n, 1'b0);
    ak_never = 1'b0;
    wait_drain(20, "to_late_drain");
    chk("to_err_sticky", grant_err, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
